spi_master_shifter: RTL and testbench

- Mode-0 (CPOL=0, CPHA=0), MSB-first SPI master shift engine.
- Sits directly downstream of the SPI clock-divider stage and consumes its 2x-SCLK-rate enable pulse (`tick`).
- Each `tick` is one SCLK half-period. The block toggles SCLK on ticks and serialises one word per transfer.
- It deserialises MISO at the same time and hands the received word to the system through a valid/ready-style interface.

---
 rtl/spi_master_shifter.sv | 144 ++++++++++++++
 tb/tb_spi_master_shifter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_shifter.sv
// Mode-0 MSB-first SPI master shift engine, paced by a 2x-SCLK tick from the divider.
// Serialises tx_data on MOSI while capturing MISO, and returns the received word with a one-clk rx_valid pulse.
module spi_master_shifter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_e;

    state_e              state_q,    state_d;
    logic                sclk_q,     sclk_d;
    logic                cs_n_q,     cs_n_d;
    logic                mosi_q,     mosi_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0]   rx_data_q,  rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                busy_q,     busy_d;
    logic                tx_ready_q, tx_ready_d;

    // Next-state and next-output logic; every tick-driven step is gated by tick.
    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // tick is deliberately ignored here, even in the acceptance cycle
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    cs_n_d     = 1'b0;
                    mosi_d     = tx_data[DATA_W-1];
                    bit_cnt_d  = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == CNT_W'(DATA_W)) begin
                            state_d = HOLD;
                        end else begin
                            // next bit goes out on the falling edge
                            tx_shift_d = tx_shift_q << 1;
                            mosi_d     = tx_shift_q[DATA_W-2];
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d     = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    mosi_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        tx_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: directed scenarios plus random transfers against a tick-counting model.
module tb_spi_master_shifter;

    localparam int DW = 8;
    localparam int TICKS = 2 * DW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          cs_n;

    int n_cmp = 0;
    int n_err = 0;
    int last_cslow = 0;

    spi_master_shifter #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer. The model counts post-accept ticks: tick 1 is setup, even ticks 2..2*DW
    // are SCLK rises (sampling MISO), odd ticks fall, tick 2*DW+2 ends the word.
    // per: 0 = random tick, else tick every per-th clk after acceptance.
    // mmode: 0 = loopback, 1 = MISO held high, 2 = random MISO.
    task automatic xfer(input logic [DW-1:0] data, input int per, input int mmode,
                        input bit tk_acc, input bit hold, input logic [DW-1:0] nxt);
        int t;
        int j;
        int rises;
        int rxv;
        int cslow;
        bit tk;
        logic prev_sclk;
        logic [DW-1:0] exp_rx;
        logic [4:0] e;

        tx_data  = data;
        tx_valid = 1'b1;
        tick     = tk_acc;
        miso     = 1'($urandom_range(0, 1));
        chk("tx_ready_pre", 32'(tx_ready), 32'd1);
        step();
        chk("accept", 32'({busy, tx_ready, cs_n, sclk, mosi}), 32'({1'b1, 1'b0, 1'b0, 1'b0, data[DW-1]}));
        cslow    = (cs_n == 1'b0) ? 1 : 0;
        tx_valid = hold;
        tx_data  = hold ? nxt : DW'($urandom);
        t = 0; rises = 0; rxv = 0; exp_rx = '0;

        for (int k = 1; k <= 4000 && t < TICKS; k++) begin
            tk   = (per == 0) ? ($urandom_range(0, 1) == 1) : ((k % per) == 0);
            tick = tk;
            case (mmode)
                0:       miso = mosi;
                1:       miso = 1'b1;
                default: miso = 1'($urandom_range(0, 1));
            endcase
            if (tk && ((t + 1) % 2 == 0) && (t + 1 >= 2) && (t + 1 <= 2 * DW)) begin
                j = (t + 1) / 2;
                exp_rx = {exp_rx[DW-2:0], miso};
                chk("mosi_bit", 32'(mosi), 32'(data[DW-j]));
            end
            prev_sclk = sclk;
            step();
            if (tk) t++;
            e = {(t >= 2 && t <= 2 * DW && (t % 2) == 0),
                 (t >= TICKS),
                 (t < TICKS),
                 (t >= TICKS),
                 (tk && t == TICKS)};
            chk("cycle", 32'({sclk, cs_n, busy, tx_ready, rx_valid}), 32'(e));
            if (!prev_sclk && sclk) rises++;
            if (rx_valid) rxv++;
            if (!cs_n) cslow++;
        end

        chk("ticks_done", 32'(t), 32'(TICKS));
        chk("rx_data", 32'(rx_data), 32'(exp_rx));
        chk("sclk_rises", 32'(rises), 32'(DW));
        chk("rx_valid_cnt", 32'(rxv), 32'd1);
        if (mmode == 0) chk("loopback", 32'(rx_data), 32'(data));
        last_cslow = cslow;
    endtask

    initial begin
        int rises;
        int rxv;
        logic prev_sclk;

        rst = 1'b0; tick = 1'b0; tx_data = '0; tx_valid = 1'b0; miso = 1'b0;
        step(); step(); step();
        chk("reset_outs", 32'({sclk, cs_n, mosi, rx_valid, busy, tx_ready}), 32'(6'b010001));
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b1;
        step();

        // 1: loopback, tick tied high
        xfer(8'hA5, 1, 0, 1'b1, 1'b0, 8'h00);
        tick = 1'b0;
        step();

        // 2: tick every 4th clk, MISO high
        xfer(8'h3C, 4, 1, 1'b1, 1'b0, 8'h00);
        chk("cs_low_clks", 32'(last_cslow), 32'd72);
        chk("rx_ff", 32'(rx_data), 32'hFF);
        tick = 1'b0;
        step();

        // 3: tx_valid held across two back-to-back words
        xfer(8'h81, 1, 0, 1'b1, 1'b1, 8'h7E);
        xfer(8'h7E, 1, 0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            step();
            chk("no_extra_xfer", 32'({busy, cs_n, rx_valid}), 32'(3'b010));
        end

        // 4: reset after the 5th SCLK rise
        tx_data = 8'h5A; tx_valid = 1'b1; tick = 1'b1;
        step();
        tx_valid = 1'b0;
        rises = 0; rxv = 0;
        for (int k = 0; k < 100 && rises < 5; k++) begin
            miso = 1'($urandom_range(0, 1));
            prev_sclk = sclk;
            step();
            if (!prev_sclk && sclk) rises++;
            if (rx_valid) rxv++;
        end
        chk("rst_rises", 32'(rises), 32'd5);
        chk("rst_no_rxv_before", 32'(rxv), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_abort", 32'({sclk, cs_n, busy, tx_ready, rx_valid, mosi}), 32'(6'b010100));
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b1;
        tick = 1'b0;
        step();

        // 5: acceptance-cycle tick ignored, then tick every 2 clks
        xfer(8'hC6, 2, 2, 1'b1, 1'b0, 8'h00);
        tick = 1'b0;

        // 6: idle with tick toggling
        for (int i = 0; i < 100; i++) begin
            tick = ~tick;
            step();
            chk("idle", 32'({sclk, cs_n, mosi, rx_valid, busy}), 32'(5'b01000));
        end

        // random transfers: data, tick pattern, MISO source and gaps
        for (int i = 0; i < 12; i++) begin
            xfer(DW'($urandom), 0, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0, 8'h00);
            tx_valid = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                tick = 1'($urandom_range(0, 1));
                step();
                chk("gap_idle", 32'({busy, cs_n}), 32'(2'b01));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
